// File: rtl/pellet_tracker.sv
// pellet_tracker
//   Owns the live pellet map read by the frame renderer. Loads the level's
//   initial layout row by row, clears a pellet when Pac-Man's sprite centre
//   sits over its dot, and reports eat events, remaining count and
//   level-clear. Map updates happen only as a result of a frame-sync pulse,
//   so the map never changes during scan-out.
//
// Ports
//   vga_clk        clock (single domain)
//   reset_n        asynchronous active-low reset
//   level_start    one-cycle pulse: reload the map from the init table
//   frame_sync     one-cycle pulse at start of vertical blank
//   pm_x, pm_y     Pac-Man sprite top-left, pixels, unsigned
//   init_row_addr  row currently being loaded
//   init_row_data  initial pellets for init_row_addr (combinational reply)
//   pellets        registered pellet map, pellets[row][col]
//   pellet_eaten   one-cycle pulse per pellet cleared
//   pellets_left   remaining pellet count
//   level_clear    all pellets gone; sticky until the next load
//   busy           high while loading
module pellet_tracker #(
    parameter int unsigned ROWS     = 31,
    parameter int unsigned COLS     = 28,
    parameter int unsigned ORIGIN_X = 110,
    parameter int unsigned ORIGIN_Y = 8,
    parameter int unsigned CELL     = 15,
    parameter int unsigned PM_HALF  = 13
) (
    input  logic            vga_clk,
    input  logic            reset_n,
    input  logic            level_start,
    input  logic            frame_sync,
    input  logic [31:0]     pm_x,
    input  logic [31:0]     pm_y,
    output logic [4:0]      init_row_addr,
    input  logic [COLS-1:0] init_row_data,
    output logic [COLS-1:0] pellets [0:ROWS-1],
    output logic            pellet_eaten,
    output logic [9:0]      pellets_left,
    output logic            level_clear,
    output logic            busy
);

    localparam int unsigned CW   = $clog2(COLS);
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned MW   = $clog2(CELL);
    // Offset width wide enough for any in-board pixel offset on either axis
    localparam int unsigned OW   = $clog2(((ROWS > COLS) ? ROWS : COLS) * CELL);
    localparam int unsigned DOT_LO = 6;
    localparam int unsigned DOT_HI = 8;

    typedef enum logic [1:0] {
        LOAD,
        IDLE,
        CHECK,
        CLEAR
    } state_t;

    state_t state, state_next;

    logic [4:0]    row;
    logic [31:0]   cx, cy;
    logic [31:0]   dx, dy;
    logic          in_board;
    logic [CW-1:0] gx;
    logic [RW-1:0] gy;
    logic [MW-1:0] ox, oy;
    logic          hit;
    logic [9:0]    load_sum;

    function automatic logic [9:0] popcount(input logic [COLS-1:0] v);
        logic [9:0] n;
        n = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            n += 10'(v[i]);
        end
        return n;
    endfunction

    assign init_row_addr = row;
    assign busy          = (state == LOAD);

    // Positions left of / above the board wrap to huge unsigned offsets,
    // so a single unsigned compare per axis rejects both sides.
    always_comb begin
        dx       = cx - 32'(ORIGIN_X);
        dy       = cy - 32'(ORIGIN_Y);
        load_sum = pellets_left + popcount(init_row_data);
        hit      = in_board
                   && (ox >= MW'(DOT_LO)) && (ox <= MW'(DOT_HI))
                   && (oy >= MW'(DOT_LO)) && (oy <= MW'(DOT_HI))
                   && pellets[gy][gx];
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (level_start) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (row == 5'(ROWS - 1)) state_next = IDLE;
                IDLE:    if (frame_sync) state_next = CHECK;
                CHECK:   state_next = CLEAR;
                CLEAR:   state_next = IDLE;
                default: state_next = LOAD;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                pellets[r] <= '0;
            end
            row          <= '0;
            pellets_left <= '0;
            level_clear  <= 1'b0;
            pellet_eaten <= 1'b0;
            cx           <= '0;
            cy           <= '0;
            in_board     <= 1'b0;
            gx           <= '0;
            gy           <= '0;
            ox           <= '0;
            oy           <= '0;
        end else begin
            pellet_eaten <= 1'b0;
            if (level_start) begin
                // Old map bits stay until each row is overwritten by the load.
                row          <= '0;
                pellets_left <= '0;
                level_clear  <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        pellets[row] <= init_row_data;
                        pellets_left <= load_sum;
                        row          <= row + 5'd1;
                        if (row == 5'(ROWS - 1) && load_sum == '0) begin
                            level_clear <= 1'b1;
                        end
                    end
                    IDLE: begin
                        if (frame_sync) begin
                            cx <= pm_x + 32'(PM_HALF);
                            cy <= pm_y + 32'(PM_HALF);
                        end
                    end
                    CHECK: begin
                        in_board <= (dx < 32'(COLS * CELL)) && (dy < 32'(ROWS * CELL));
                        // Low OW bits are exact whenever in_board holds;
                        // out-of-board results are never used.
                        gx <= CW'(dx[OW-1:0] / OW'(CELL));
                        gy <= RW'(dy[OW-1:0] / OW'(CELL));
                        ox <= MW'(dx[OW-1:0] % OW'(CELL));
                        oy <= MW'(dy[OW-1:0] % OW'(CELL));
                    end
                    CLEAR: begin
                        if (hit) begin
                            pellets[gy][gx] <= 1'b0;
                            pellet_eaten    <= 1'b1;
                            if (pellets_left != '0) begin
                                pellets_left <= pellets_left - 10'd1;
                            end
                            if (pellets_left == 10'd1) begin
                                level_clear <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pellet_tracker.sv
// tb_pellet_tracker
//   Directed bench for pellet_tracker: load, eat timing, dot-window and
//   board-edge boundaries, level-clear, reload priority, ignored frame_sync
//   and asynchronous reset during a load.
module tb_pellet_tracker;

    logic        clk;
    logic        reset_n;
    logic        level_start;
    logic        frame_sync;
    logic [31:0] pm_x;
    logic [31:0] pm_y;
    logic [4:0]  init_row_addr;
    logic [27:0] init_row_data;
    logic [27:0] pellets [0:30];
    logic        pellet_eaten;
    logic [9:0]  pellets_left;
    logic        level_clear;
    logic        busy;

    int mode;          // 0: full table, 1: only [1][1], 2: empty
    int n_checks;
    int n_errors;
    int eat_total;

    pellet_tracker #(
        .ROWS(31), .COLS(28), .ORIGIN_X(110), .ORIGIN_Y(8), .CELL(15), .PM_HALF(13)
    ) dut (
        .vga_clk      (clk),
        .reset_n      (reset_n),
        .level_start  (level_start),
        .frame_sync   (frame_sync),
        .pm_x         (pm_x),
        .pm_y         (pm_y),
        .init_row_addr(init_row_addr),
        .init_row_data(init_row_data),
        .pellets      (pellets),
        .pellet_eaten (pellet_eaten),
        .pellets_left (pellets_left),
        .level_clear  (level_clear),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign init_row_data = (mode == 0) ? 28'hFFFFFFF :
                           (mode == 1 && init_row_addr == 5'd1) ? 28'h0000002 : 28'h0;

    always @(negedge clk) begin
        if (pellet_eaten) eat_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts load edges until busy drops (bounded).
    task automatic wait_load(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // One frame_sync pulse at position (x,y), then watch six cycles.
    // first = negedge index (1-based) after the sampling edge where pellet_eaten seen.
    task automatic fs_run(input logic [31:0] x, input logic [31:0] y,
                          output int pulses, output int first, output logic lc);
        @(negedge clk);
        pm_x = x;
        pm_y = y;
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        pulses = 0;
        first  = 0;
        lc     = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (pellet_eaten) begin
                pulses++;
                if (first == 0) first = i;
                lc = level_clear;
            end
        end
    endtask

    task automatic pulse_level_start();
        @(negedge clk);
        level_start = 1'b1;
        @(negedge clk);
        level_start = 1'b0;
    endtask

    initial begin
        int cyc, p, f, e0;
        logic lc;

        n_checks    = 0;
        n_errors    = 0;
        eat_total   = 0;
        mode        = 0;
        reset_n     = 1'b0;
        level_start = 1'b0;
        frame_sync  = 1'b0;
        pm_x        = '0;
        pm_y        = '0;

        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_left", 32'(pellets_left), 32'd0);
        check("rst_clear", 32'(level_clear), 32'd0);
        check("rst_eaten", 32'(pellet_eaten), 32'd0);
        check("rst_map5", 32'(pellets[5]), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        wait_load(cyc);
        check("load_cycles", cyc, 32'd31);
        check("load_left", 32'(pellets_left), 32'd868);
        check("load_clear", 32'(level_clear), 32'd0);
        for (int r = 0; r < 31; r++) begin
            check($sformatf("load_row%0d", r), 32'(pellets[r]), 32'hFFFFFFF);
        end

        // Centre (132,30): cell (1,1), offset (7,7)
        fs_run(32'd119, 32'd17, p, f, lc);
        check("eat11_pulses", p, 32'd1);
        check("eat11_when", f, 32'd2);
        check("eat11_row1", 32'(pellets[1]), 32'hFFFFFFD);
        check("eat11_left", 32'(pellets_left), 32'd867);
        fs_run(32'd119, 32'd17, p, f, lc);
        check("reeat_pulses", p, 32'd0);
        check("reeat_left", 32'(pellets_left), 32'd867);

        // Dot-window boundaries along row 1
        fs_run(32'd133, 32'd17, p, f, lc);   // cell 2, ox 6
        check("ox6_hit", p, 32'd1);
        fs_run(32'd150, 32'd17, p, f, lc);   // cell 3, ox 8
        check("ox8_hit", p, 32'd1);
        fs_run(32'd166, 32'd17, p, f, lc);   // cell 4, ox 9
        check("ox9_miss", p, 32'd0);
        fs_run(32'd177, 32'd17, p, f, lc);   // cell 5, ox 5
        check("ox5_miss", p, 32'd0);
        fs_run(32'd138, 32'd17, p, f, lc);   // cell 2 region, ox 11
        check("ox11_miss", p, 32'd0);
        fs_run(32'd194, 32'd18, p, f, lc);   // cell 6, oy 8
        check("oy8_hit", p, 32'd1);
        fs_run(32'd209, 32'd19, p, f, lc);   // cell 7, oy 9
        check("oy9_miss", p, 32'd0);
        fs_run(32'd0, 32'd0, p, f, lc);      // left/above board
        check("origin_miss", p, 32'd0);
        fs_run(32'hFFFFFFF0, 32'd17, p, f, lc);
        check("wrap_miss", p, 32'd0);
        fs_run(32'd509, 32'd452, p, f, lc);  // last cell (27,30), offset 7,7
        check("corner_hit", p, 32'd1);
        fs_run(32'd524, 32'd452, p, f, lc);  // one column past the board
        check("right_miss", p, 32'd0);
        check("row1_after", 32'(pellets[1]), 32'hFFFFFB1);
        check("row30_after", 32'(pellets[30]), 32'h7FFFFFF);
        check("left_after", 32'(pellets_left), 32'd863);

        // Reload with frame_sync during LOAD, then restart mid-load
        e0 = eat_total;
        pm_x = 32'd119;
        pm_y = 32'd17;
        pulse_level_start();
        check("ls_busy", 32'(busy), 32'd1);
        check("ls_left0", 32'(pellets_left), 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            frame_sync = (i == 4);
        end
        frame_sync = 1'b0;
        level_start = 1'b1;
        @(negedge clk);
        level_start = 1'b0;
        wait_load(cyc);
        check("restart_cycles", cyc, 32'd31);
        check("restart_left", 32'(pellets_left), 32'd868);
        check("restart_row1", 32'(pellets[1]), 32'hFFFFFFF);
        @(negedge clk);
        check("fs_in_load", eat_total - e0, 32'd0);

        // frame_sync also high in CHECK, aimed at another pellet: ignored
        @(negedge clk);
        pm_x = 32'd119;
        pm_y = 32'd17;
        frame_sync = 1'b1;
        @(negedge clk);
        pm_x = 32'd134;                      // cell (2,1)
        @(negedge clk);
        frame_sync = 1'b0;
        e0 = eat_total;
        repeat (5) @(negedge clk);
        check("fs_check_pulses", eat_total - e0, 32'd1);
        check("fs_check_row1", 32'(pellets[1]), 32'hFFFFFFD);
        check("fs_check_left", 32'(pellets_left), 32'd867);

        // Empty table: level_clear right after load
        mode = 2;
        pulse_level_start();
        wait_load(cyc);
        check("empty_left", 32'(pellets_left), 32'd0);
        check("empty_clear", 32'(level_clear), 32'd1);

        // Single pellet: eating it clears the level
        mode = 1;
        pulse_level_start();
        check("single_ls_clear", 32'(level_clear), 32'd0);
        wait_load(cyc);
        check("single_left", 32'(pellets_left), 32'd1);
        check("single_clear0", 32'(level_clear), 32'd0);
        fs_run(32'd119, 32'd17, p, f, lc);
        check("last_pulses", p, 32'd1);
        check("last_clear_with_eat", 32'(lc), 32'd1);
        check("last_left", 32'(pellets_left), 32'd0);
        fs_run(32'd119, 32'd17, p, f, lc);
        check("none_left", 32'(pellets_left), 32'd0);

        mode = 0;
        pulse_level_start();
        check("relevel_clear", 32'(level_clear), 32'd0);
        check("relevel_busy", 32'(busy), 32'd1);
        wait_load(cyc);
        check("relevel_left", 32'(pellets_left), 32'd868);

        // Asynchronous reset in the middle of a load
        pulse_level_start();
        repeat (6) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_left", 32'(pellets_left), 32'd0);
        check("arst_map0", 32'(pellets[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_load(cyc);
        check("arst_cycles", cyc, 32'd31);
        check("arst_reload", 32'(pellets_left), 32'd868);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pellet_tracker.md
# pellet_tracker

Owns the live pellet map the frame renderer reads as `pellets[0:30]`: loads the level's initial pellet layout, clears a pellet when Pac-Man's centre sits over it, and reports eat events, remaining count and level-clear. Sits between the game-logic registers (Pac-Man position) and the pixel mapper. All map updates are committed only on the frame-sync pulse, so the map never changes mid-scanout.

## Interface
- ROWS, 31, board rows
- COLS, 28, board columns (bit index = column)
- ORIGIN_X, 110, board left edge in pixels
- ORIGIN_Y, 8, board top edge in pixels
- CELL, 15, cell size in pixels
- PM_HALF, 13, offset from Pac-Man top-left to sprite centre
- vga_clk  in  1  clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- level_start  in  1  one-cycle pulse: reload map from init table
- frame_sync  in  1  one-cycle pulse at start of vertical blank
- pm_x  in  32  Pac-Man sprite left, pixels, unsigned
- pm_y  in  32  Pac-Man sprite top, pixels, unsigned
- init_row_addr  out  5  row being loaded
- init_row_data  in  COLS  initial pellets for init_row_addr, combinational, same cycle
- pellets  out  COLS x ROWS  unpacked `[COLS-1:0] pellets[0:ROWS-1]`, registered
- pellet_eaten  out  1  one-cycle pulse per pellet cleared
- pellets_left  out  10  remaining pellets
- level_clear  out  1  level complete, sticky until next load
- busy  out  1  high in LOAD

## Operation
- States: LOAD, IDLE, CHECK, CLEAR.
- Reset: all pellets 0, pellets_left 0, level_clear 0, pellet_eaten 0, row counter 0, state LOAD, busy 1. Load starts automatically on reset release.
- LOAD: each cycle, pellets[row] <= init_row_data; pellets_left += popcount(init_row_data); row++. After row ROWS-1 -> IDLE, busy 0. If the loaded total is 0, level_clear <= 1.
- IDLE: on frame_sync, latch cx = pm_x+PM_HALF and cy = pm_y+PM_HALF (32-bit, wrap permitted) -> CHECK.
- CHECK: register in_board = (cx-ORIGIN_X < COLS*CELL) && (cy-ORIGIN_Y < ROWS*CELL), unsigned compares, so positions left/above the board wrap to large values and miss. Register gx, gy = offset/CELL and ox, oy = offset%CELL. -> CLEAR.
- CLEAR: hit = in_board && ox in [6,8] && oy in [6,8] && pellets[gy][gx]. On hit: clear the bit, pellet_eaten 1 for one cycle, pellets_left--, and if pellets_left was 1, level_clear <= 1. -> IDLE.
- level_start has top priority in every state: row 0, pellets_left 0, level_clear 0, busy 1, state LOAD. Old pellet bits remain until each row is overwritten.
- frame_sync outside IDLE is ignored, not queued.
- pellets_left never decrements below 0. A hit requires the bit to be set, so double-eating is impossible.

## Timing
- Load latency: busy falls, and pellets_left is final, in the cycle after ROWS (31) load edges.
- frame_sync sampled at edge N: CHECK runs at N+1, CLEAR at N+2. The pellet bit, pellets_left and pellet_eaten all change together after edge N+2. pellet_eaten is low again after N+3.
- Maximum of one pellet eaten per frame_sync.
- level_clear rises in the same cycle as the final pellet_eaten.
- Asynchronous reset mid-operation returns to the reset values immediately, then reloads.

## Test plan
- Reset, init_row_data = 28'hFFFFFFF for every row -> busy high for 31 cycles, then pellets_left = 868 and all pellets set.
- Full map, pm_x=119, pm_y=17 (centre 132,30 -> cell 1,1, offset 7,7), pulse frame_sync -> pellets[1][1] = 0, one pellet_eaten pulse 3 cycles later, pellets_left = 867. Repeat the pulse -> no pulse, count unchanged.
- Off-dot, pm_x=123, pm_y=17 (ox=11) -> no clear. Also pm_x=0, pm_y=0 (outside the board) and pm_x=32'hFFFFFFF0 (wrap) -> no clear.
- Map with only pellet [1][1] set (pellets_left=1), eat it -> pellets_left = 0, level_clear rises with pellet_eaten. Then level_start -> level_clear 0, busy 1, reload to 868.
- level_start asserted at load row 15 -> load restarts at row 0, final pellets_left equals a single full-table load.
- frame_sync asserted during LOAD and during CHECK -> ignored, with no eat even when positioned on a pellet.
